fetch_ctl: RTL
==============

Name: fetch_ctl

Overview:
Fetch sequencer and instruction buffer between the instruction-memory port and decode.
- Generates sequential PCs and issues credit-limited requests to imem.
- Buffers in-order responses and presents them to decode on valid_de0/instr_de0 under stall_de1 backpressure.
- Handles backend redirects by flushing the buffer and dropping in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset.
IBUF_DEPTH, 4, instruction buffer entries; power of 2, >=2; also caps requests in flight.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
redirect_valid  in  1  backend redirect request
redirect_pc  in  32  redirect target PC
imem_req_valid  out  1  fetch request valid
imem_req_pc  out  32  fetch request PC
imem_req_ready  in  1  imem accepts request
imem_rsp_valid  in  1  in-order response; no backpressure
imem_rsp_instr  in  32  response data (t_rv_instr)
valid_de0  out  1  instruction valid to decode
instr_de0  out  32  instruction to decode (t_rv_instr)
pc_de0  out  32  PC of instr_de0
stall_de1  in  1  decode stall; head not consumed

Behaviour:
- Clocking and reset: single clock clk; reset is synchronous and active-high.
- Reset values (reset asserted, and the cycle after): state=RUN, req_pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, drop_cnt=0, ibuf empty. Therefore valid_de0=0, imem_req_valid=0 while reset is high.
- Reset mid-operation discards all buffered and in-flight state. Responses arriving after reset deasserts for pre-reset requests are a bench protocol violation.
- Handshakes:
  - req_fire = imem_req_valid & imem_req_ready.
  - pop = valid_de0 & ~stall_de1.
  - Once imem_req_valid is asserted, req_pc is held stable until req_fire or redirect.
- Request issue: imem_req_valid = (state==RUN) & ~reset & (outstanding + ibuf_count < IBUF_DEPTH). It is combinational from registered state only, with no path from redirect_valid or rsp.
  - On req_fire: req_pc += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0); outstanding += 1.
- Responses in RUN:
  - imem_rsp_valid pushes {rsp_pc, imem_rsp_instr} into ibuf; rsp_pc += 4; outstanding -= 1.
  - Credit rule guarantees no overflow; push when full is an assertion failure.
  - imem_rsp_valid with outstanding==0 and drop_cnt==0 is an assertion failure.
- Decode output: valid_de0 = ibuf non-empty; instr_de0/pc_de0 = head entry, 0 when empty. Head is held while stall_de1=1.
  - Push and pop in the same cycle are allowed; the count is unchanged. A push to an empty buffer is visible the next cycle (one-cycle rsp->de0 latency).
- Counters: outstanding and drop_cnt are $clog2(IBUF_DEPTH+1) bits; ibuf_count is 0..IBUF_DEPTH.
- State machine (t_fetch_state):
  - RUN: normal operation. Redirect -> FLUSH if new drop_cnt>0, else stay RUN.
  - FLUSH: no requests issued. Each imem_rsp_valid is discarded and drop_cnt -= 1. drop_cnt==0 -> RUN next cycle.
- Redirect (highest priority, any state, takes effect next cycle):
  - ibuf cleared. A head shown in the redirect cycle counts as squashed even if popped.
  - req_pc = rsp_pc = redirect_pc.
  - drop_cnt_next = outstanding + drop_cnt + req_fire - imem_rsp_valid. A response in the redirect cycle is discarded, not pushed.
  - outstanding = 0.
  - Back-to-back redirects: the last one wins; counts accumulate per the formula above.

Decomposition:
- Package fetch_pkg:
  - t_fetch_state enum {RUN, FLUSH}.
  - t_ibuf_entry struct {pc[31:0], instr t_rv_instr}.
  - FETCH_PC_INCR = 4.
- Sub-module fetch_ibuf: parameterized sync FIFO of t_ibuf_entry.
  - Ports: push, pop, clear, head, count, empty, full.
  - Pointer wrap uses an extra MSB.
  - Clear has priority over push/pop.
- fetch_ctl holds the FSM, PC registers and counters.

Test Plan:
1. RESET_PC=0x1000, imem latency 2, ready=1, stall_de1=0 -> requests at 0x1000, 0x1004, 0x1008...; pc_de0 sequence matches with correct instr; first valid_de0 exactly 1 cycle after first rsp.
2. stall_de1=1 for 12 cycles -> at most 4 requests fired (outstanding+count<=4); head pc 0x1000 held stable; after release, all 4 delivered in order, none lost or duplicated.
3. redirect_pc=0x2000 with 3 outstanding -> FLUSH; next 3 rsps dropped; next request pc 0x2000; first valid_de0 has pc_de0=0x2000.
4. redirect coinciding with req_fire and imem_rsp_valid, outstanding=2 -> drop_cnt=2; exactly 2 later rsps dropped; 3rd delivered as 0x2000.
5. imem_req_ready=0 for 5 cycles -> imem_req_valid stays 1, imem_req_pc constant; req_pc=0xFFFF_FFFC -> next 0x0000_0000.
6. reset asserted with full ibuf and 2 outstanding -> valid_de0=0, imem_req_valid=0 during reset; after release, first request pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch sequencer and its instruction buffer.
package fetch_pkg;
   typedef logic [31:0] t_rv_instr;
   typedef enum logic {RUN, FLUSH} t_fetch_state;
   typedef struct packed {
      logic [31:0] pc;
      t_rv_instr   instr;
   } t_ibuf_entry;
   localparam logic [31:0] FETCH_PC_INCR = 32'd4;
endpackage

// File: rtl/fetch_ibuf.sv
// fetch_ibuf: synchronous FIFO of fetched {pc, instr} entries; clear beats push/pop.
module fetch_ibuf
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  t_ibuf_entry              din,
   output t_ibuf_entry              head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = (AW+1)'(1);
   t_ibuf_entry r_mem [DEPTH];
   logic [AW:0] r_wp, r_rp;
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (push) r_wp <= r_wp + ONE;
         if (pop && !empty) r_rp <= r_rp + ONE;
      end
   end
   always_ff @(posedge clk) begin
      if (push) r_mem[r_wp[AW-1:0]] <= din;
   end
   // extra pointer MSB distinguishes full from empty
   assign count = r_wp - r_rp;
   assign empty = (r_wp == r_rp);
   assign full  = (count == (AW+1)'(DEPTH));
   assign head  = r_mem[r_rp[AW-1:0]];
endmodule

// File: rtl/fetch_ctl.sv
// fetch_ctl: sequential PC generation, credit-limited imem requests, and redirect flushing.
module fetch_ctl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IBUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_pc,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  t_rv_instr   imem_rsp_instr,
   output logic        valid_de0,
   output t_rv_instr   instr_de0,
   output logic [31:0] pc_de0,
   input  logic        stall_de1
);
   localparam int CW = $clog2(IBUF_DEPTH + 1);
   t_fetch_state r_state;
   logic [31:0] r_req_pc, r_rsp_pc;
   logic [CW-1:0] r_out, r_drop;
   logic [CW-1:0] w_count, w_drop_next;
   logic [CW:0] w_inflight;
   logic w_empty, w_full, w_fire, w_push, w_pop;
   t_ibuf_entry w_head;
   fetch_ibuf #(.DEPTH(IBUF_DEPTH)) u_ibuf (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .clear (redirect_valid),
      .din   ('{pc: r_rsp_pc, instr: imem_rsp_instr}),
      .head  (w_head),
      .count (w_count),
      .empty (w_empty),
      .full  (w_full)
   );
   // buffered plus in-flight never exceeds the buffer, so a response always has a slot
   assign w_inflight     = {1'b0, r_out} + {1'b0, w_count};
   assign imem_req_valid = (r_state == RUN) && !reset && (w_inflight < (CW+1)'(IBUF_DEPTH));
   assign imem_req_pc    = r_req_pc;
   assign w_fire         = imem_req_valid && imem_req_ready;
   assign w_push         = (r_state == RUN) && imem_rsp_valid && !redirect_valid;
   assign valid_de0      = !w_empty && !reset;
   assign w_pop          = valid_de0 && !stall_de1;
   assign instr_de0      = valid_de0 ? w_head.instr : '0;
   assign pc_de0         = valid_de0 ? w_head.pc : '0;
   assign w_drop_next    = r_out + r_drop + CW'(w_fire) - CW'(imem_rsp_valid);
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= RUN;
         r_req_pc <= RESET_PC;
         r_rsp_pc <= RESET_PC;
         r_out    <= '0;
         r_drop   <= '0;
      end else if (redirect_valid) begin
         r_state  <= (w_drop_next != '0) ? FLUSH : RUN;
         r_req_pc <= redirect_pc;
         r_rsp_pc <= redirect_pc;
         r_out    <= '0;
         r_drop   <= w_drop_next;
      end else if (r_state == RUN) begin
         if (w_fire) r_req_pc <= r_req_pc + FETCH_PC_INCR;
         if (imem_rsp_valid) r_rsp_pc <= r_rsp_pc + FETCH_PC_INCR;
         r_out <= r_out + CW'(w_fire) - CW'(imem_rsp_valid);
      end else begin
         r_drop  <= w_drop_next;
         r_state <= (w_drop_next == '0) ? RUN : FLUSH;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(w_push && w_full && !w_pop));
         assert (!(imem_rsp_valid && r_out == '0 && r_drop == '0));
      end
   end
endmodule
